uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  8N1 UART receiver: serial RxD in, parallel byte out. Pairs with the team's UART transmitter
//  (same 8N1 framing: start bit 0, LSB first, stop bit 1, same bit period) for a host->FPGA command path.
//  Mid-bit sampling, false-start rejection, framing-error detection.
//  Output holding register with valid/ack handshake and overrun flag.
// PARAMETERS
//  CLKS_PER_BIT  28  clk cycles per bit; must be >= 8. Default matches transmitter baud counter (0..27).
// PORTS
//  clk          in   1  system clock (100 MHz)
//  reset        in   1  synchronous, active-high
//  rxd          in   1  asynchronous serial input, idle high
//  rx_data      out  8  last received byte (holding register)
//  rx_valid     out  1  rx_data holds an unconsumed byte; held high until acknowledged
//  rx_ack       in   1  consumer accepts rx_data; clears rx_valid next cycle
//  framing_err  out  1  1-cycle pulse: stop bit sampled 0
//  overrun      out  1  1-cycle pulse: byte completed while rx_valid=1 and rx_ack=0
//  busy         out  1  high in any state other than IDLE
// BEHAVIOUR
//  - Sync: rxd -> 2 flops (both reset to 1) -> rxs. All decisions use rxs only (2-cycle input delay).
//  - Bit counter cnt: 0..CLKS_PER_BIT-1. Bit index bidx: 0..7. Shift register sh[7:0], right shift, MSB in.
//  - States: IDLE, START, DATA, STOP, WAIT_HIGH.
//  - IDLE: rxs==0 -> START, cnt<=0.
//  - START: at cnt==CLKS_PER_BIT/2-1 sample rxs. If 1 -> false start -> IDLE, no output.
//    If 0 -> DATA, cnt<=0, bidx<=0. Otherwise cnt increments.
//  - DATA: at cnt==CLKS_PER_BIT-1 (mid-bit) shift rxs into sh[7], cnt<=0.
//    If bidx==7 -> STOP, else bidx++.
//  - STOP: at cnt==CLKS_PER_BIT-1 sample rxs.
//    - 1: rx_data<=sh, rx_valid<=1 (next cycle) -> IDLE.
//    - 0: framing_err pulse, byte discarded, rx_data/rx_valid unchanged -> WAIT_HIGH.
//  - WAIT_HIGH: stay until rxs==1, then IDLE. Prevents a break (line held 0) from retriggering.
//  - Latency: rx_valid rises 1 clk after the stop-bit sample point,
//    i.e. ~9.5 bit periods + 3 clk after the rxd falling edge.
//  - Handshake:
//    - rx_ack while rx_valid=1 -> rx_valid=0 next cycle.
//    - rx_ack while rx_valid=0 is ignored.
//  - Simultaneous rx_ack and byte completion: new byte loaded, rx_valid stays 1, no overrun.
//  - Overrun: byte completes with rx_valid=1 and rx_ack=0 -> rx_data overwritten with the new byte,
//    rx_valid stays 1, overrun pulses 1 cycle.
//  - Reset values: rx_data=8'h00, rx_valid=0, framing_err=0, overrun=0, busy=0, state=IDLE.
//    Reset mid-frame aborts the frame; no output for it. A partially seen frame after reset release
//    may be received as garbage or rejected; the next clean frame must be received correctly.
//  - framing_err and overrun never assert in the same cycle.
//  - No rx_data change except on a successful stop bit or reset.
// TESTING
//  1. Send 8'hA5 at CLKS_PER_BIT=28 (bit = 28 clk) -> rx_valid=1, rx_data=8'hA5;
//     hold rx_ack=0 -> rx_valid stays 1; pulse rx_ack -> rx_valid=0 next clk.
//  2. Back-to-back 8'h00, 8'hFF, 8'h55 (no idle gap), rx_ack 1 clk after each rx_valid
//     -> three bytes in order, no framing_err/overrun.
//  3. rxd low for 10 clk then high (glitch < half bit) -> returns to IDLE, rx_valid=0, busy drops,
//     no error pulse.
//  4. Frame 8'h3C with stop bit forced 0, then line held low 40 clk -> one framing_err pulse,
//     rx_valid=0, stays WAIT_HIGH until rxd=1; next frame 8'h81 received correctly.
//  5. Send 8'h11 then 8'h22 without ack -> overrun pulse once, rx_data=8'h22.
//     Repeat with rx_ack asserted on the completion cycle -> no overrun, rx_data=8'h22, rx_valid=1.
//  6. Assert reset during bit 4 of 8'hC3 -> busy=0, rx_valid=0 after reset;
//     following frame 8'h7E received as 8'h7E. Loopback with the transmitter: send 8'h5A -> 8'h5A.

Source files
------------

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver for the host->FPGA command path. Framing: one start bit
//   (0), eight data bits LSB first, one stop bit (1), CLKS_PER_BIT clocks per
//   bit. Each bit is sampled at its middle. A start bit that is gone by its
//   middle is treated as a glitch. A stop bit sampled low is reported as a
//   framing error and the byte is dropped.
//
//   Output handshake: o_rx_valid is high while o_rx_data holds a byte the
//   consumer has not taken yet. The consumer takes it by raising i_rx_ack in
//   any cycle where o_rx_valid is high, and o_rx_valid falls on the next clock.
//   i_rx_ack is ignored while o_rx_valid is low. If a new byte completes in
//   the same cycle as the ack, the new byte is loaded and o_rx_valid stays
//   high. If a new byte completes while an older byte is still unacknowledged,
//   the older byte is overwritten and o_overrun pulses for one cycle.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high
//   i_rxd          in   asynchronous serial input, idle high
//   o_rx_data      out  [7:0] holding register, last good byte
//   o_rx_valid     out  holding register contains an unconsumed byte
//   i_rx_ack       in   consumer takes o_rx_data
//   o_framing_err  out  1-cycle pulse: stop bit sampled low
//   o_overrun      out  1-cycle pulse: unconsumed byte overwritten
//   o_busy         out  receiver is not idle
//   o_dbg_state    out  [2:0] current FSM state (debug)
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rxd,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ack,
    output logic       o_framing_err,
    output logic       o_overrun,
    output logic       o_busy,
    output logic [2:0] o_dbg_state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LP_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // Two-flop synchronizer; both stages reset to the idle level so that
    // reset release never looks like a start bit.
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rxs;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bidx;
    logic [7:0]    r_sh;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_framing_err;
    logic          r_overrun;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_bidx_nxt;
    logic [7:0]    w_sh_nxt;
    logic [7:0]    w_rx_data_nxt;
    logic          w_rx_valid_nxt;
    logic          w_framing_err_nxt;
    logic          w_overrun_nxt;

    assign w_rxs = r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bidx        <= 3'd0;
            r_sh          <= 8'h00;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_sync1       <= i_rxd;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_bidx        <= w_bidx_nxt;
            r_sh          <= w_sh_nxt;
            r_rx_data     <= w_rx_data_nxt;
            r_rx_valid    <= w_rx_valid_nxt;
            r_framing_err <= w_framing_err_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_bidx_nxt        = r_bidx;
        w_sh_nxt          = r_sh;
        w_rx_data_nxt     = r_rx_data;
        // An ack only matters while a byte is held; a completing byte below
        // overrides this and keeps valid high.
        w_rx_valid_nxt    = r_rx_valid & ~i_rx_ack;
        w_framing_err_nxt = 1'b0;
        w_overrun_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end

            S_START: begin
                if (r_cnt == LP_HALF) begin
                    w_cnt_nxt  = '0;
                    w_bidx_nxt = 3'd0;
                    // Line back high by mid-start: a glitch, not a frame.
                    w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (r_cnt == LP_LAST) begin
                    w_cnt_nxt = '0;
                    // LSB arrives first, so shift right and insert at the MSB.
                    w_sh_nxt  = {w_rxs, r_sh[7:1]};
                    if (r_bidx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bidx_nxt = r_bidx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (r_cnt == LP_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_rx_data_nxt  = r_sh;
                        w_rx_valid_nxt = 1'b1;
                        w_overrun_nxt  = r_rx_valid & ~i_rx_ack;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_framing_err_nxt = 1'b1;
                        w_state_nxt       = S_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            // A break holds the line low; wait for idle so it cannot be
            // mistaken for a fresh start bit.
            S_WAIT_HIGH: begin
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_framing_err = r_framing_err;
    assign o_overrun     = r_overrun;
    assign o_busy        = (r_state != S_IDLE);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Bench for uart_receiver. A serial driver plays the transmitter; a
//   scoreboard holds the bytes that must appear on the parallel side, in
//   order, and counts the error pulses that must appear.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CPB = 28;
    // Start edge to rx_valid: 9.5 bit periods plus 3 clocks
    // (2 synchronizer stages + 1 clock to leave idle).
    localparam int LAT = (19 * CPB) / 2 + 3;

    logic       clk;
    logic       reset;
    logic       i_rxd;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       i_rx_ack;
    logic       o_framing_err;
    logic       o_overrun;
    logic       o_busy;
    logic [2:0] o_dbg_state;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_rxd         (i_rxd),
        .o_rx_data     (o_rx_data),
        .o_rx_valid    (o_rx_valid),
        .i_rx_ack      (i_rx_ack),
        .o_framing_err (o_framing_err),
        .o_overrun     (o_overrun),
        .o_busy        (o_busy),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         fe_cnt  = 0;
    int         ov_cnt  = 0;
    int         fe_exp  = 0;
    int         ov_exp  = 0;
    logic       prev_valid;
    logic       prev_ack;
    logic [7:0] prev_data;
    logic       load;
    logic       rand_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: a byte is loaded when valid rises, when valid survives
    // an ack, or when an overrun replaces the held byte.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
            prev_data  = o_rx_data;
        end else begin
            load = o_rx_valid && (!prev_valid || prev_ack || o_overrun);
            if (load) begin
                if (exp_q.size() == 0) check("byte_unexpected", exp_q.size(), 1);
                else                   check("rx_data", o_rx_data, exp_q.pop_front());
            end else if (o_rx_data != prev_data) begin
                check("data_stable", o_rx_data, prev_data);
            end
            if (o_framing_err) fe_cnt++;
            if (o_overrun)     ov_cnt++;
            if (o_framing_err || o_overrun)
                check("fe_ov_exclusive", o_framing_err & o_overrun, 0);
            prev_valid = o_rx_valid;
            prev_ack   = i_rx_ack;
            prev_data  = o_rx_data;
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end just after a rising edge.
    task automatic idle(input int n);
        i_rxd = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_v);
        if (stop_v) exp_q.push_back(d);
        else        fe_exp++;
        i_rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            i_rxd = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        i_rxd = stop_v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        i_rx_ack = 1'b1;
        @(posedge clk);
        #1;
        i_rx_ack = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!o_rx_valid && n < LAT + 2 * CPB) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, o_rx_valid, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [7:0] d;
        logic       bad;

        reset     = 1'b1;
        i_rxd     = 1'b1;
        i_rx_ack  = 1'b0;
        rand_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data",  o_rx_data, 8'h00);
        check("rst_valid", o_rx_valid, 0);
        check("rst_fe",    o_framing_err, 0);
        check("rst_ov",    o_overrun, 0);
        check("rst_busy",  o_busy, 0);
        reset = 1'b0;
        idle(5);

        // 1: single byte, latency, hold and ack
        fork
            send_byte(8'hA5, 1'b1);
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                end while (!o_rx_valid && n < LAT + 100);
                check("t1_latency", n, LAT);
            end
        join
        check("t1_data", o_rx_data, 8'hA5);
        idle(20);
        check("t1_hold_valid", o_rx_valid, 1);
        pulse_ack();
        check("t1_ack_clears", o_rx_valid, 0);
        pulse_ack();
        check("t1_ack_ignored", o_rx_valid, 0);
        idle(CPB);

        // 2: back-to-back frames, ack one clock after each valid
        fork
            begin
                send_byte(8'h00, 1'b1);
                send_byte(8'hFF, 1'b1);
                send_byte(8'h55, 1'b1);
            end
            for (int k = 0; k < 3; k++) begin
                wait_valid("t2_valid");
                @(posedge clk);
                #1;
                pulse_ack();
            end
        join
        idle(CPB);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_fe", fe_cnt, fe_exp);
        check("t2_ov", ov_cnt, ov_exp);

        // 3: glitch shorter than half a bit
        i_rxd = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("t3_busy_during", o_busy, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        idle(30);
        check("t3_busy_after", o_busy, 0);
        check("t3_valid", o_rx_valid, 0);
        check("t3_fe", fe_cnt, fe_exp);

        // 4: bad stop bit followed by a break, then a clean frame
        send_byte(8'h3C, 1'b0);
        i_rxd = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("t4_fe_pulse", fe_cnt, fe_exp);
        check("t4_busy_break", o_busy, 1);
        check("t4_valid", o_rx_valid, 0);
        check("t4_data_kept", o_rx_data, 8'h55);
        idle(10);
        check("t4_busy_idle", o_busy, 0);
        send_byte(8'h81, 1'b1);
        wait_valid("t4_valid_81");
        pulse_ack();
        check("t4_queue_empty", exp_q.size(), 0);

        // 5a: overrun
        idle(CPB);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        ov_exp++;
        check("t5_ov", ov_cnt, ov_exp);
        check("t5_data", o_rx_data, 8'h22);
        check("t5_valid", o_rx_valid, 1);
        pulse_ack();
        idle(CPB);

        // 5b: ack on the completion cycle of the second byte
        send_byte(8'h11, 1'b1);
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                i_rx_ack = 1'b1;
                @(posedge clk);
                #1;
                i_rx_ack = 1'b0;
            end
        join
        check("t5b_ov", ov_cnt, ov_exp);
        check("t5b_data", o_rx_data, 8'h22);
        check("t5b_valid", o_rx_valid, 1);

        // 6: reset during bit 4 of 8'hC3 (valid still held from 5b)
        d = 8'hC3;
        i_rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            i_rxd = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        i_rxd = d[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        i_rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_busy", o_busy, 0);
        check("t6_valid", o_rx_valid, 0);
        check("t6_data", o_rx_data, 8'h00);
        idle(2 * CPB);
        send_byte(8'h7E, 1'b1);
        wait_valid("t6_valid_7e");
        pulse_ack();
        idle(CPB);
        send_byte(8'h5A, 1'b1);
        wait_valid("t6_valid_5a");
        pulse_ack();
        idle(CPB);
        check("t6_queue_empty", exp_q.size(), 0);

        // Random frames: random data, gaps, ack delays and bad stop bits
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    d   = 8'($urandom_range(0, 255));
                    bad = ($urandom_range(0, 5) == 0);
                    send_byte(d, !bad);
                    if (bad) idle(CPB + $urandom_range(0, CPB));
                    else     idle($urandom_range(0, 2 * CPB));
                end
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                @(posedge clk);
                #1;
                if (o_rx_valid && !i_rx_ack) begin
                    repeat ($urandom_range(0, 4)) begin
                        @(posedge clk);
                        #1;
                    end
                    pulse_ack();
                end
            end
        join
        idle(2 * CPB);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_fe", fe_cnt, fe_exp);
        check("rand_ov", ov_cnt, ov_exp);
        check("rand_valid", o_rx_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
